// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and constants for the CPU/host memory arbiter
package cpu_mem_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
   localparam logic REQ_CPU  = 1'b0;
   localparam logic REQ_HOST = 1'b1;
   localparam logic [1:0] BE_LO   = 2'b01;
   localparam logic [1:0] BE_HI   = 2'b10;
   localparam logic [1:0] BE_WORD = 2'b11;
   typedef struct packed {
      logic        we;
      logic        is_byte;
      logic [7:0]  addr;
      logic [15:0] wdata;
   } mem_req_t;
endpackage

// File: rtl/arb_grant.sv
// arb_grant: host-priority grant with a CPU starvation counter
module arb_grant #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic cpu_valid,
   input  logic host_valid,
   output logic cpu_ready,
   output logic host_ready
);
   logic [3:0] starve_cnt;
   logic       host_win;
   logic       starved;
   // host wins unless the CPU is waiting and has lost STARVE_LIMIT times in a row
   always_comb begin
      starved    = 32'(starve_cnt) >= STARVE_LIMIT;
      host_win   = host_valid && !(cpu_valid && starved);
      host_ready = idle && host_win;
      cpu_ready  = idle && cpu_valid && !host_win;
   end
   // count consecutive arbitrations lost by a waiting CPU, saturating at the limit
   always_ff @(posedge clk or posedge rst)
      if (rst) starve_cnt <= '0;
      else if (cpu_ready) starve_cnt <= '0;
      else if (host_ready && cpu_valid && !starved) starve_cnt <= starve_cnt + 4'd1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port 16-bit RAM between the CPU and the host loader
module mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int MEMORY_SIZE  = 32,
   parameter int STARVE_LIMIT = 4,
   localparam int AW = $clog2(MEMORY_SIZE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req_valid,
   output logic          cpu_req_ready,
   input  logic          cpu_req_we,
   input  logic          cpu_req_byte,
   input  logic [7:0]    cpu_req_addr,
   input  logic [15:0]   cpu_req_wdata,
   output logic          cpu_rsp_valid,
   output logic [15:0]   cpu_rsp_data,
   output logic          cpu_rsp_err,
   input  logic          host_req_valid,
   output logic          host_req_ready,
   input  logic          host_req_we,
   input  logic          host_req_byte,
   input  logic [7:0]    host_req_addr,
   input  logic [15:0]   host_req_wdata,
   output logic          host_rsp_valid,
   output logic [15:0]   host_rsp_data,
   output logic          host_rsp_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [1:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   input  logic [15:0]   mem_rdata
);
   arb_state_t  state, next;
   mem_req_t    in_req;
   logic [7:0]  in_word;
   logic [1:0]  in_be;
   logic [15:0] in_wdata;
   logic        in_oor, idle, take, resp;
   logic        id, rd_we, rd_byte, rd_hi, err;
   logic [15:0] rsp_data;
   arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
      .clk(clk), .rst(rst), .idle(idle),
      .cpu_valid(cpu_req_valid), .host_valid(host_req_valid),
      .cpu_ready(cpu_req_ready), .host_ready(host_req_ready)
   );
   // select the granted request and decode it to word index, lanes and write data
   always_comb begin
      in_req   = host_req_ready ? {host_req_we, host_req_byte, host_req_addr, host_req_wdata}
                                : {cpu_req_we, cpu_req_byte, cpu_req_addr, cpu_req_wdata};
      in_word  = in_req.is_byte ? {1'b0, in_req.addr[7:1]} : in_req.addr;
      in_oor   = 32'(in_word) >= MEMORY_SIZE;
      in_be    = in_req.is_byte ? (in_req.addr[0] ? BE_HI : BE_LO) : BE_WORD;
      in_wdata = in_req.is_byte ? {2{in_req.wdata[7:0]}} : in_req.wdata;
   end
   // next state: one cycle each in ISSUE and RESP; ready is held off during reset
   always_comb begin
      idle = state == IDLE && !rst;
      take = cpu_req_ready || host_req_ready;
      resp = state == RESP;
      next = state == IDLE ? (take ? ISSUE : IDLE) : state == ISSUE ? RESP : IDLE;
   end
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next;
   // RAM pins are loaded at the handshake so they are live only during ISSUE
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         id        <= REQ_CPU;
         rd_we     <= 1'b0;
         rd_byte   <= 1'b0;
         rd_hi     <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_en    <= take && !in_oor;
         mem_we    <= take && !in_oor && in_req.we;
         mem_be    <= take ? in_be : '0;
         mem_addr  <= take ? in_word[AW-1:0] : '0;
         mem_wdata <= take ? in_wdata : '0;
         if (take) begin
            id      <= host_req_ready;
            rd_we   <= in_req.we;
            rd_byte <= in_req.is_byte;
            rd_hi   <= in_req.addr[0];
            err     <= in_oor;
         end
      end
   // steer read data (lane-extracted for byte reads) to the requester that owns RESP
   always_comb begin
      rsp_data = (resp && !err && !rd_we)
               ? (rd_byte ? {8'h00, rd_hi ? mem_rdata[15:8] : mem_rdata[7:0]} : mem_rdata)
               : 16'h0000;
      cpu_rsp_valid  = resp && id == REQ_CPU;
      host_rsp_valid = resp && id == REQ_HOST;
      cpu_rsp_data   = cpu_rsp_valid ? rsp_data : 16'h0000;
      host_rsp_data  = host_rsp_valid ? rsp_data : 16'h0000;
      cpu_rsp_err    = cpu_rsp_valid && err;
      host_rsp_err   = host_rsp_valid && err;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a behavioural RAM
module tb_mem_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic        cpu_req_valid = 0, cpu_req_ready, cpu_req_we = 0, cpu_req_byte = 0;
   logic [7:0]  cpu_req_addr = 0;
   logic [15:0] cpu_req_wdata = 0;
   logic        cpu_rsp_valid, cpu_rsp_err;
   logic [15:0] cpu_rsp_data;
   logic        host_req_valid = 0, host_req_ready, host_req_we = 0, host_req_byte = 0;
   logic [7:0]  host_req_addr = 0;
   logic [15:0] host_req_wdata = 0;
   logic        host_rsp_valid, host_rsp_err;
   logic [15:0] host_rsp_data;
   logic        mem_en, mem_we;
   logic [1:0]  mem_be;
   logic [4:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata = 0;
   logic [15:0] ram [32];
   int          total = 0, passed = 0, cyc = 0;
   int          hs [3];

   mem_arbiter #(.MEMORY_SIZE(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
      .cpu_req_byte(cpu_req_byte), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_err(cpu_rsp_err),
      .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_req_we(host_req_we),
      .host_req_byte(host_req_byte), .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
      .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data), .host_rsp_err(host_rsp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      if (mem_en) begin
         if (mem_we && mem_be[0]) ram[mem_addr][7:0] <= mem_wdata[7:0];
         if (mem_we && mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
         mem_rdata <= ram[mem_addr];
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // one complete transaction starting at an IDLE negedge, ending at the next IDLE negedge
   task automatic access(input string tag, input logic host, input logic we, input logic byt,
                         input logic [7:0] addr, input logic [15:0] wd, input logic en,
                         input logic [1:0] be, input logic [4:0] maddr, input logic [15:0] mwd,
                         input logic [15:0] rd, input logic err);
      if (host) begin
         host_req_valid = 1; host_req_we = we; host_req_byte = byt;
         host_req_addr = addr; host_req_wdata = wd;
      end else begin
         cpu_req_valid = 1; cpu_req_we = we; cpu_req_byte = byt;
         cpu_req_addr = addr; cpu_req_wdata = wd;
      end
      #1;
      chk({tag, ".ready"}, host ? host_req_ready : cpu_req_ready, 1);
      chk({tag, ".other_ready"}, host ? cpu_req_ready : host_req_ready, 0);
      @(negedge clk);
      chk({tag, ".mem_en"}, mem_en, en);
      if (en) begin
         chk({tag, ".mem_we"}, mem_we, we);
         chk({tag, ".mem_be"}, mem_be, be);
         chk({tag, ".mem_addr"}, mem_addr, maddr);
         chk({tag, ".mem_wdata"}, mem_wdata, mwd);
      end
      chk({tag, ".ready_issue"}, host ? host_req_ready : cpu_req_ready, 0);
      host_req_valid = 0;
      cpu_req_valid = 0;
      @(negedge clk);
      chk({tag, ".rsp_valid"}, host ? host_rsp_valid : cpu_rsp_valid, 1);
      chk({tag, ".other_rsp"}, host ? cpu_rsp_valid : host_rsp_valid, 0);
      chk({tag, ".rsp_data"}, host ? host_rsp_data : cpu_rsp_data, rd);
      chk({tag, ".rsp_err"}, host ? host_rsp_err : cpu_rsp_err, err);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ram[i] = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst.mem_en", mem_en, 0);
      chk("rst.cpu_ready", cpu_req_ready, 0);
      chk("rst.host_rsp", host_rsp_valid, 0);
      rst = 0;
      @(negedge clk);
      access("h_wr3", 1, 1, 0, 8'd3, 16'hA55A, 1, 2'b11, 5'd3, 16'hA55A, 16'h0000, 0);
      access("h_rd3", 1, 0, 0, 8'd3, 16'h0000, 1, 2'b11, 5'd3, 16'h0000, 16'hA55A, 0);
      access("c_bwr7", 0, 1, 1, 8'd7, 16'h005C, 1, 2'b10, 5'd3, 16'h5C5C, 16'h0000, 0);
      access("c_brd7", 0, 0, 1, 8'd7, 16'h0000, 1, 2'b10, 5'd3, 16'h0000, 16'h005C, 0);
      access("c_brd6", 0, 0, 1, 8'd6, 16'h0000, 1, 2'b01, 5'd3, 16'h0000, 16'h005A, 0);
      access("c_wrd3", 0, 0, 0, 8'd3, 16'h0000, 1, 2'b11, 5'd3, 16'h0000, 16'h5C5A, 0);
      access("c_oor32", 0, 0, 0, 8'd32, 16'h0000, 0, 2'b11, 5'd0, 16'h0000, 16'h0000, 1);
      access("h_oor_bwr64", 1, 1, 1, 8'd64, 16'h00FF, 0, 2'b01, 5'd0, 16'hFFFF, 16'h0000, 1);
      access("c_wrd0", 0, 0, 0, 8'd0, 16'h0000, 1, 2'b11, 5'd0, 16'h0000, 16'h0000, 0);
      access("c_bwr63", 0, 1, 1, 8'd63, 16'h0011, 1, 2'b10, 5'd31, 16'h1111, 16'h0000, 0);
      access("h_wrd31", 1, 0, 0, 8'd31, 16'h0000, 1, 2'b11, 5'd31, 16'h0000, 16'h1100, 0);
      // both valid continuously: H,H,H,H,C repeating
      cpu_req_valid = 1; cpu_req_we = 0; cpu_req_byte = 0; cpu_req_addr = 8'd3;
      host_req_valid = 1; host_req_we = 0; host_req_byte = 0; host_req_addr = 8'd3;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("starve.host_ready%0d", i), host_req_ready, (i % 5) != 4);
         chk($sformatf("starve.cpu_ready%0d", i), cpu_req_ready, (i % 5) == 4);
         if (i == 4) chk("starve.cnt_sat", dut.u_grant.starve_cnt, 4);
         @(negedge clk);
         if (i % 5 == 4) chk($sformatf("starve.cnt_clr%0d", i), dut.u_grant.starve_cnt, 0);
         @(negedge clk);
         chk($sformatf("starve.rsp%0d", i), (i % 5) == 4 ? cpu_rsp_valid : host_rsp_valid, 1);
         @(negedge clk);
      end
      cpu_req_valid = 0;
      host_req_valid = 0;
      @(negedge clk);
      // CPU alone, back to back
      cpu_req_valid = 1; cpu_req_addr = 8'd3;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("b2b.ready%0d", k), cpu_req_ready, 1);
         hs[k] = cyc;
         @(negedge clk);
         chk($sformatf("b2b.ready_issue%0d", k), cpu_req_ready, 0);
         @(negedge clk);
         chk($sformatf("b2b.ready_resp%0d", k), cpu_req_ready, 0);
         chk($sformatf("b2b.rsp%0d", k), cpu_rsp_data, 16'h5C5A);
         @(negedge clk);
      end
      cpu_req_valid = 0;
      chk("b2b.gap1", hs[1] - hs[0], 3);
      chk("b2b.gap2", hs[2] - hs[1], 3);
      // reset during ISSUE of a host read
      host_req_valid = 1; host_req_addr = 8'd3;
      #1;
      chk("rstmid.ready", host_req_ready, 1);
      @(negedge clk);
      chk("rstmid.issue_en", mem_en, 1);
      rst = 1;
      host_req_valid = 0;
      #1;
      chk("rstmid.mem_en", mem_en, 0);
      chk("rstmid.mem_be", mem_be, 0);
      chk("rstmid.mem_addr", mem_addr, 0);
      chk("rstmid.host_rsp", host_rsp_valid, 0);
      @(negedge clk);
      chk("rstmid.no_rsp", host_rsp_valid, 0);
      rst = 0;
      host_req_valid = 1;
      #1;
      chk("rstmid.ready_after", host_req_ready, 1);
      @(negedge clk);
      chk("rstmid.reissue_en", mem_en, 1);
      chk("rstmid.reissue_addr", mem_addr, 3);
      host_req_valid = 0;
      @(negedge clk);
      chk("rstmid.rsp", host_rsp_valid, 1);
      chk("rstmid.rsp_data", host_rsp_data, 16'h5C5A);
      @(negedge clk);
      chk("rstmid.idle_rsp", host_rsp_valid, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
